// File: rtl/ex_stage_pkg.sv
// Shared ALU operation encodings and EX/MEM control bundle for the execute stage.
package ex_stage_pkg;

    localparam int ALU_OP_W = 4;
    typedef logic [ALU_OP_W-1:0] alu_op_t;

    localparam alu_op_t ALU_ADDU = 4'd0;
    localparam alu_op_t ALU_SUBU = 4'd1;
    localparam alu_op_t ALU_AND  = 4'd2;
    localparam alu_op_t ALU_OR   = 4'd3;
    localparam alu_op_t ALU_XOR  = 4'd4;
    localparam alu_op_t ALU_NOR  = 4'd5;
    localparam alu_op_t ALU_SLT  = 4'd6;
    localparam alu_op_t ALU_SLTU = 4'd7;
    localparam alu_op_t ALU_SLLV = 4'd8;
    localparam alu_op_t ALU_SRLV = 4'd9;
    localparam alu_op_t ALU_SRAV = 4'd10;
    localparam alu_op_t ALU_LUI  = 4'd11;
    localparam alu_op_t ALU_XXX  = 4'd15;

    typedef struct packed {
        logic [4:0]  rd;
        logic        regWrite;
        logic        memRead;
        logic        memWrite;
        logic [31:0] storeData;
    } ctrl_t;

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational execute datapath; unknown codes give a zero result and flag illegal.
module alu
    import ex_stage_pkg::*;
(
    input  alu_op_t     aluOp,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    input  logic [4:0]  shiftAmt,
    output logic [31:0] result,
    output logic        illegal
);

    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (aluOp)
            ALU_ADDU: result = opA + opB;
            ALU_SUBU: result = opA - opB;
            ALU_AND:  result = opA & opB;
            ALU_OR:   result = opA | opB;
            ALU_XOR:  result = opA ^ opB;
            ALU_NOR:  result = ~(opA | opB);
            ALU_SLT:  result = {31'b0, $signed(opA) < $signed(opB)};
            ALU_SLTU: result = {31'b0, opA < opB};
            ALU_SLLV: result = opB << shiftAmt;
            ALU_SRLV: result = opB >> shiftAmt;
            ALU_SRAV: result = $unsigned($signed(opB) >>> shiftAmt);
            ALU_LUI:  result = {opB[15:0], 16'h0000};
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// EX/MEM pipeline register with valid/ready handshake and flush around the ALU.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  alu_op_t     aluOp,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    input  logic [4:0]  shamt,
    input  logic        useShamt,
    input  logic [4:0]  rd,
    input  logic        regWrite,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [31:0] storeData,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        zero,
    output logic        illegalOp,
    output logic [4:0]  out_rd,
    output logic        out_regWrite,
    output logic        out_memRead,
    output logic        out_memWrite,
    output logic [31:0] out_storeData
);

    logic        valid_q, zero_q, illegal_q;
    logic [31:0] result_q;
    ctrl_t       ctrl_q, ctrl_d;
    logic [31:0] alu_res;
    logic        alu_ill, accept;
    logic [4:0]  shift_amt;

    assign shift_amt = useShamt ? shamt : opA[4:0];

    alu u_alu (
        .aluOp    (aluOp),
        .opA      (opA),
        .opB      (opB),
        .shiftAmt (shift_amt),
        .result   (alu_res),
        .illegal  (alu_ill)
    );

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // An illegal op must never write registers or touch memory downstream.
    always_comb begin
        ctrl_d           = '0;
        ctrl_d.rd        = rd;
        ctrl_d.regWrite  = regWrite && !alu_ill;
        ctrl_d.memRead   = memRead  && !alu_ill;
        ctrl_d.memWrite  = memWrite && !alu_ill;
        ctrl_d.storeData = storeData;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q   <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
            ctrl_q    <= '0;
        end else if (flush) begin
            valid_q         <= 1'b0;
            ctrl_q.regWrite <= 1'b0;
            ctrl_q.memRead  <= 1'b0;
            ctrl_q.memWrite <= 1'b0;
        end else if (accept) begin
            valid_q   <= 1'b1;
            result_q  <= alu_res;
            zero_q    <= (alu_res == 32'd0);
            illegal_q <= alu_ill;
            ctrl_q    <= ctrl_d;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid     = valid_q;
    assign result        = result_q;
    assign zero          = zero_q;
    assign illegalOp     = illegal_q;
    assign out_rd        = ctrl_q.rd;
    assign out_regWrite  = ctrl_q.regWrite;
    assign out_memRead   = ctrl_q.memRead;
    assign out_memWrite  = ctrl_q.memWrite;
    assign out_storeData = ctrl_q.storeData;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench: directed corner cases plus random traffic against a behavioural model.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic        clock, reset;
    logic        in_valid, in_ready, useShamt, regWrite, memRead, memWrite, flush;
    logic        out_valid, out_ready, zero, illegalOp;
    logic        out_regWrite, out_memRead, out_memWrite;
    logic [3:0]  aluOp;
    logic [31:0] opA, opB, storeData, result, out_storeData;
    logic [4:0]  shamt, rd, out_rd;

    int checks = 0;
    int failures = 0;

    // expected registered state
    logic        e_valid, e_zero, e_ill, e_rw, e_mr, e_mw;
    logic [31:0] e_res, e_sd;
    logic [4:0]  e_rd;

    ex_stage dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .aluOp(aluOp), .opA(opA), .opB(opB), .shamt(shamt), .useShamt(useShamt),
        .rd(rd), .regWrite(regWrite), .memRead(memRead), .memWrite(memWrite),
        .storeData(storeData), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero), .illegalOp(illegalOp),
        .out_rd(out_rd), .out_regWrite(out_regWrite), .out_memRead(out_memRead),
        .out_memWrite(out_memWrite), .out_storeData(out_storeData)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                    input logic [4:0] n, output logic [31:0] r, output logic il);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        il = 1'b0;
        r  = 32'd0;
        case (op)
            ALU_ADDU: r = 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
            ALU_SUBU: r = 32'((64'(a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000);
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
            ALU_NOR:  r = ~(a | b);
            ALU_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
            ALU_SLTU: r = (64'(a) < 64'(b)) ? 32'd1 : 32'd0;
            ALU_SLLV: r = 32'(64'(b) * (64'd1 << n));
            ALU_SRLV: r = b / (32'd1 << n);
            // floor division gives arithmetic right shift
            ALU_SRAV: begin
                longint q;
                q = sb / (longint'(1) << n);
                if (sb < 0 && (sb % (longint'(1) << n)) != 0) q = q - 1;
                r = 32'(q);
            end
            ALU_LUI:  r = b[15:0] * 32'h10000;
            default:  il = 1'b1;
        endcase
    endfunction

    task automatic drive(input logic iv, input logic ordy, input logic fl, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                         input logic us, input logic [4:0] d, input logic rw, input logic mr,
                         input logic mw, input logic [31:0] sd);
        in_valid = iv; out_ready = ordy; flush = fl; aluOp = op; opA = a; opB = b;
        shamt = sh; useShamt = us; rd = d; regWrite = rw; memRead = mr; memWrite = mw;
        storeData = sd;
    endtask

    task automatic model_reset();
        e_valid = 0; e_zero = 0; e_ill = 0; e_rw = 0; e_mr = 0; e_mw = 0;
        e_res = 0; e_sd = 0; e_rd = 0;
    endtask

    task automatic check_outputs(input string pfx);
        chk({pfx, ".out_valid"}, {31'b0, out_valid}, {31'b0, e_valid});
        chk({pfx, ".result"}, result, e_res);
        chk({pfx, ".zero"}, {31'b0, zero}, {31'b0, e_zero});
        chk({pfx, ".illegalOp"}, {31'b0, illegalOp}, {31'b0, e_ill});
        chk({pfx, ".out_rd"}, {27'b0, out_rd}, {27'b0, e_rd});
        chk({pfx, ".ctrl"}, {29'b0, out_regWrite, out_memRead, out_memWrite}, {29'b0, e_rw, e_mr, e_mw});
        chk({pfx, ".storeData"}, out_storeData, e_sd);
    endtask

    // Called at a falling edge with inputs already driven; advances one cycle.
    task automatic step(input string pfx);
        logic        acc, il;
        logic [31:0] r;
        #1;
        chk({pfx, ".in_ready"}, {31'b0, in_ready}, {31'b0, (!e_valid || out_ready)});
        acc = in_valid && (!e_valid || out_ready);
        ref_alu(aluOp, opA, opB, useShamt ? shamt : opA[4:0], r, il);
        @(posedge clock);
        if (flush) begin
            e_valid = 0; e_rw = 0; e_mr = 0; e_mw = 0;
        end else if (acc) begin
            e_valid = 1; e_res = r; e_zero = (r == 0); e_ill = il;
            e_rd = rd; e_sd = storeData;
            e_rw = regWrite && !il; e_mr = memRead && !il; e_mw = memWrite && !il;
        end else if (out_ready) begin
            e_valid = 0;
        end
        #1;
        check_outputs(pfx);
        @(negedge clock);
    endtask

    initial begin
        model_reset();
        drive(0, 1, 0, ALU_ADDU, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        #1;
        check_outputs("reset");
        chk("reset.in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;

        drive(1, 1, 0, ALU_ADDU, 32'hFFFFFFFF, 32'd1, 0, 0, 5'd3, 1, 0, 0, 32'hAA);
        step("addu_wrap");
        chk("addu_wrap.zero_direct", {31'b0, zero}, 32'd1);
        drive(1, 1, 0, ALU_SLT, 32'hFFFFFFFE, 32'd1, 0, 0, 5'd4, 1, 0, 0, 0);
        step("slt");
        chk("slt.result_direct", result, 32'd1);
        drive(1, 1, 0, ALU_SLTU, 32'hFFFFFFFE, 32'd1, 0, 0, 5'd4, 1, 0, 0, 0);
        step("sltu");
        chk("sltu.result_direct", result, 32'd0);
        drive(1, 1, 0, ALU_SRAV, 32'd4, 32'h80000000, 5'd9, 0, 5'd5, 1, 0, 0, 0);
        step("srav");
        chk("srav.result_direct", result, 32'hF8000000);
        drive(1, 1, 0, ALU_SLLV, 32'd0, 32'd1, 5'd31, 1, 5'd6, 1, 0, 0, 0);
        step("sll_shamt");
        chk("sll_shamt.result_direct", result, 32'h80000000);
        drive(1, 1, 0, ALU_SRLV, 32'd0, 32'h1234_5678, 5'd0, 1, 5'd7, 1, 0, 0, 0);
        step("shift0");
        chk("shift0.result_direct", result, 32'h1234_5678);
        drive(1, 1, 0, ALU_XXX, 32'd7, 32'd9, 0, 0, 5'd8, 1, 1, 1, 32'h55);
        step("illegal");
        chk("illegal.flag_direct", {31'b0, illegalOp, out_regWrite}, {30'b0, 2'b10});

        // stall: hold the next instruction for three cycles, then release
        drive(1, 1, 0, ALU_OR, 32'hF0, 32'h0F, 0, 0, 5'd10, 1, 0, 0, 32'h1);
        step("stall_a");
        drive(1, 0, 0, ALU_SUBU, 32'd5, 32'd7, 0, 0, 5'd11, 1, 0, 1, 32'h2);
        for (int i = 0; i < 3; i++) begin
            step("stall_hold");
            chk("stall_hold.result_frozen", result, 32'hFF);
        end
        out_ready = 1'b1;
        step("stall_release");
        chk("stall_release.result_b", result, 32'hFFFFFFFE);
        in_valid = 1'b0;
        step("stall_drain");

        // flush kills a held instruction and a same-cycle acceptance
        drive(1, 0, 0, ALU_AND, 32'hFF, 32'h3C, 0, 0, 5'd12, 1, 1, 0, 0);
        step("pre_flush");
        drive(1, 0, 1, ALU_ADDU, 32'd1, 32'd1, 0, 0, 5'd13, 1, 0, 1, 0);
        step("flush_stalled");
        drive(1, 1, 1, ALU_ADDU, 32'd1, 32'd1, 0, 0, 5'd13, 1, 0, 1, 0);
        step("flush_accept");
        chk("flush_accept.valid_direct", {31'b0, out_valid}, 32'd0);

        // async reset in the middle of a cycle with a valid held output
        drive(1, 0, 0, ALU_XOR, 32'h5, 32'h3, 0, 0, 5'd14, 1, 0, 0, 32'h77);
        step("pre_reset");
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_outputs("async_reset");
        chk("async_reset.in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clock);
        reset = 1'b1;
        chk("post_reset.in_ready", {31'b0, in_ready}, 32'd1);
        drive(1, 1, 0, ALU_LUI, 32'd0, 32'h0000_1234, 0, 0, 5'd15, 1, 0, 0, 0);
        step("lui");
        chk("lui.result_direct", result, 32'h1234_0000);

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                  4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom,
                  5'($urandom), 1'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), $urandom);
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL provide ports: clock  in  1  single system clock, all state updates on rising edge.
REQ-002 SHALL provide: reset  in  1  asynchronous, active-low reset (asserted at 0).
REQ-003 SHALL provide: in_valid  in  1  decode stage presents an instruction; in_ready  out  1  stage can accept it.
REQ-004 SHALL provide: aluOp  in  4  ALU operation code from the ALU-control decoder (ALU_* encodings, incl. ALU_XXX).
REQ-005 SHALL provide: opA  in  32  rs value; opB  in  32  rt value or extended immediate.
REQ-006 SHALL provide: shamt  in  5  instruction shift field; useShamt  in  1  1 = shift by shamt (SLL/SRL/SRA), 0 = by opA[4:0].
REQ-007 SHALL provide: rd  in  5  destination register; regWrite, memRead, memWrite  in  1 each  control bits; storeData  in  32  rt for stores.
REQ-008 SHALL provide: flush  in  1  kill the instruction being accepted and the one held.
REQ-009 SHALL provide: out_valid  out  1; out_ready  in  1  memory-stage handshake.
REQ-010 SHALL provide: result  out  32; zero  out  1 (result == 0); illegalOp  out  1.
REQ-011 SHALL provide: out_rd  out  5; out_regWrite, out_memRead, out_memWrite  out  1; out_storeData  out  32 (registered copies).

Function
REQ-012 SHALL be one pipeline register (EX/MEM); accepted instruction appears on outputs exactly 1 cycle after acceptance.
REQ-013 SHALL drive in_ready = !out_valid || out_ready (combinational); accept when in_valid && in_ready.
REQ-014 SHALL, on out_valid && out_ready with no acceptance, clear out_valid next cycle.
REQ-015 SHALL hold all outputs stable while out_valid && !out_ready (stall); no input accepted.
REQ-016 SHALL, when flush=1, clear out_valid and all out_* control bits next cycle, discard any same-cycle acceptance; flush wins over accept and stall.
REQ-017 SHALL compute ADDU/SUBU modulo 2^32, no overflow trap.
REQ-018 SHALL compute AND, OR, XOR, NOR bitwise on opA, opB.
REQ-019 SHALL compute SLT signed, SLTU unsigned; result 32'd1 if opA<opB else 32'd0.
REQ-020 SHALL shift opB: SLLV logical left, SRLV logical right, SRAV arithmetic right; amount = useShamt ? shamt : opA[4:0].
REQ-021 SHALL compute LUI as {opB[15:0], 16'h0000}.
REQ-022 SHALL, for ALU_XXX or any unlisted code, register result=0, illegalOp=1, out_regWrite=0, out_memRead=0, out_memWrite=0, out_valid as normal.
REQ-023 SHALL register zero from computed result, not recompute from outputs.
REQ-024 SHALL pass rd, storeData unchanged; shift by 0 returns opB unchanged.

Reset
REQ-025 SHALL, on reset=0, immediately clear out_valid, illegalOp, zero, out_regWrite, out_memRead, out_memWrite, and set result, out_rd, out_storeData to 0.
REQ-026 SHALL discard any in-flight instruction on reset mid-operation; first acceptance possible on first rising edge after reset=1.
REQ-027 SHALL keep in_ready=1 during and immediately after reset.

Structure
REQ-028 SHALL take ALU_* operation codes and 4-bit width from the shared parameters include; no local redefinition.
REQ-029 SHALL place datapath in one combinational sub-module alu (aluOp, opA, opB, shiftAmt -> result, illegal); ex_stage holds the register and handshake.

Verification
REQ-030 ADDU opA=32'hFFFFFFFF, opB=1, out_ready=1 -> next cycle result=0, zero=1, out_valid=1.
REQ-031 SLT opA=32'hFFFFFFFE, opB=1 -> result=1; SLTU same operands -> result=0.
REQ-032 SRAV opB=32'h80000000, opA=4, useShamt=0 -> 32'hF8000000; SLL useShamt=1 shamt=31 opB=1 -> 32'h80000000.
REQ-033 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs frozen; release -> next instruction after 1 cycle, none lost or duplicated.
REQ-034 aluOp=ALU_XXX regWrite=1 -> illegalOp=1, out_regWrite=0; flush with in_valid=1 -> out_valid=0 next cycle.
REQ-035 reset=0 asserted mid-stream between clock edges -> out_valid=0 without waiting for clock; LUI opB=16'h1234 after release -> 32'h12340000.
